wb_commit_unit: RTL and testbench
=================================

Name: wb_commit_unit

Overview:
Writeback/commit stage that consumes the MEM/WB pipeline register outputs and drives the write ports of the scalar register file and the matrix register file. Scalar and single-line matrix writes commit with 1-cycle registered latency. A MOPA result (4 lines) is serialized through the single matrix write port over 4 cycles, and the upstream pipeline is stalled while that happens. The block also tracks retired instructions.

Parameters:
XLEN, 32, data width of scalar registers and matrix lines
MLINES, 4, matrix lines per MOPA result; fixed at 4, and mx_waddr width is 2
CNT_W, 32, width of retire counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
wb_mem_data  in  XLEN  load data
wb_alu_o  in  XLEN  ALU result
wb_rd  in  5  scalar destination register
wb_mem2reg  in  1  scalar data = wb_mem_data
wb_regs_write  in  1  scalar write request
wb_matrix_index  in  2  matrix line index for single-line write
wb_mem2matrix  in  1  matrix line data = wb_mem_data
wb_matrix_write  in  1  single-line matrix write request
wb_matrix_write_mopa  in  1  4-line MOPA result write request
wb_mem_matrix2reg  in  2  non-zero: scalar data = wb_matrix_line_data
wb_matrix_line_data  in  XLEN  matrix line read for move-to-scalar
wb_mem_reg2matrix  in  1  matrix line data = wb_regs_data1
wb_regs_data1  in  XLEN  rs1 value
wb_matrix_mul_o  in  4 x XLEN  MOPA result lines 0..3
wb_inst  in  32  instruction word; 0 = bubble
rf_we  out  1  scalar write enable
rf_waddr  out  5  scalar write address
rf_wdata  out  XLEN  scalar write data
mx_we  out  1  matrix write enable
mx_waddr  out  2  matrix line address
mx_wdata  out  XLEN  matrix line data
wb_stall  out  1  combinational hold request to IF..MEM/WB
commit_valid  out  1  one instruction retired this cycle
commit_inst  out  32  retired instruction word
retire_cnt  out  CNT_W  retired instruction count

Behaviour:
- Reset (rst=0, asynchronous): every registered output = 0; FSM = IDLE; line counter = 0; MOPA buffer = 0. wb_stall = 0 while in reset.
- Accept: inputs are sampled only when the FSM is in IDLE. While in MOPA, inputs are ignored; upstream holds them.
- Scalar path, 1 cycle after accept:
  - rf_we = wb_regs_write && wb_rd != 0.
  - rf_waddr = wb_rd.
  - rf_wdata priority: wb_mem2reg ? wb_mem_data : (wb_mem_matrix2reg != 0 ? wb_matrix_line_data : wb_alu_o).
- Single-line matrix path, when wb_matrix_write=1 and wb_matrix_write_mopa=0, 1 cycle after accept:
  - mx_we = 1, mx_waddr = wb_matrix_index.
  - mx_wdata priority: wb_mem2matrix ? wb_mem_data : (wb_mem_reg2matrix ? wb_regs_data1 : wb_alu_o).
- MOPA path:
  - wb_matrix_write_mopa=1 in IDLE takes precedence over wb_matrix_write (single-line request dropped).
  - Capture cycle: capture lines 1..3 into the buffer; register line 0 to the output (mx_we=1, mx_waddr=0); go to MOPA with cnt=1.
  - Each following edge in MOPA: emit buffer[cnt] to address cnt; cnt++. After emitting line 3, return to IDLE.
  - Line order is fixed 0,1,2,3, on 4 consecutive cycles.
- Stall: wb_stall = (IDLE && wb_matrix_write_mopa) || (MOPA && cnt != 3).
  - Result: 3 stall cycles. Stall is low in the cycle whose edge writes line 3, and the next instruction is accepted in IDLE on the following cycle.
- Simultaneous scalar + MOPA: the scalar write commits on the same cycle as line 0, once only. Held inputs during MOPA never re-issue the scalar write.
- Outside accept/MOPA emission: rf_we = 0 and mx_we = 0. Data/address outputs hold their last values.
- Commit:
  - commit_valid = 1 and commit_inst = wb_inst one cycle after the accept of any wb_inst != 0.
  - During MOPA continuation cycles, commit_valid = 0.
  - retire_cnt increments with every commit_valid and wraps modulo 2^CNT_W.
- Reset mid-MOPA: all lines not yet emitted are discarded; the FSM returns to IDLE immediately and wb_stall deasserts.

Test Plan:
- Reset, then ALU op wb_rd=5, wb_alu_o=0x1234, wb_inst=0x00A00293 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, commit_valid=1, retire_cnt=1.
- Load wb_mem2reg=1, wb_mem_data=0xDEADBEEF, wb_rd=0 -> rf_we=0; commit_valid=1.
- Matrix write wb_matrix_index=2, wb_mem2matrix=1, wb_mem_data=0xCAFE0001 -> mx_we=1, mx_waddr=2, mx_wdata=0xCAFE0001; wb_stall never asserted.
- MOPA with wb_matrix_mul_o = {0x44,0x33,0x22,0x11} (lines 3..0), held 4 cycles by the bench -> mx_we=1 on 4 consecutive cycles, addresses 0,1,2,3 with data 0x11,0x22,0x33,0x44; wb_stall high exactly 3 cycles; retire_cnt +1 only.
- MOPA with wb_matrix_write=1 and wb_regs_write=1, wb_rd=7 -> rf write to 7 once, alongside line 0; no single-line matrix write.
- rst=0 asserted after line 1 of a MOPA -> outputs 0 asynchronously; after release, no further mx_we; the next ALU op commits normally.

Source files
------------

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: drives scalar and matrix register-file write ports,
// serializes 4-line MOPA results over the single matrix port, and counts retirements.
module wb_commit_unit #(
  parameter int XLEN   = 32,
  parameter int MLINES = 4,
  parameter int CNT_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [XLEN-1:0]             wb_mem_data,
  input  logic [XLEN-1:0]             wb_alu_o,
  input  logic [4:0]                  wb_rd,
  input  logic                        wb_mem2reg,
  input  logic                        wb_regs_write,
  input  logic [1:0]                  wb_matrix_index,
  input  logic                        wb_mem2matrix,
  input  logic                        wb_matrix_write,
  input  logic                        wb_matrix_write_mopa,
  input  logic [1:0]                  wb_mem_matrix2reg,
  input  logic [XLEN-1:0]             wb_matrix_line_data,
  input  logic                        wb_mem_reg2matrix,
  input  logic [XLEN-1:0]             wb_regs_data1,
  input  logic [MLINES-1:0][XLEN-1:0] wb_matrix_mul_o,
  input  logic [31:0]                 wb_inst,
  output logic                        rf_we,
  output logic [4:0]                  rf_waddr,
  output logic [XLEN-1:0]             rf_wdata,
  output logic                        mx_we,
  output logic [1:0]                  mx_waddr,
  output logic [XLEN-1:0]             mx_wdata,
  output logic                        wb_stall,
  output logic                        commit_valid,
  output logic [31:0]                 commit_inst,
  output logic [CNT_W-1:0]            retire_cnt,
  output logic                        dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_MOPA = 1'b1} state_t;

  state_t          state;
  logic [1:0]      cnt;
  logic [XLEN-1:0] mopa_buf [MLINES];

  assign dbg_state = state;

  // Handshake: upstream holds its MEM/WB outputs on any cycle where wb_stall=1;
  // inputs are only consumed on an edge taken in IDLE. Stall drops one cycle
  // early (cnt==3) so the next instruction is ready when IDLE resumes.
  always_comb begin
    wb_stall = 1'b0;
    if (rst)
      wb_stall = (state == S_IDLE && wb_matrix_write_mopa) ||
                 (state == S_MOPA && cnt != 2'd3);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= 2'd0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      mx_we        <= 1'b0;
      mx_waddr     <= '0;
      mx_wdata     <= '0;
      commit_valid <= 1'b0;
      commit_inst  <= '0;
      retire_cnt   <= '0;
      for (int i = 0; i < MLINES; i++) mopa_buf[i] <= '0;
    end else begin
      rf_we        <= 1'b0;
      mx_we        <= 1'b0;
      commit_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          rf_we    <= wb_regs_write && (wb_rd != 5'd0);
          rf_waddr <= wb_rd;
          if (wb_mem2reg)                     rf_wdata <= wb_mem_data;
          else if (wb_mem_matrix2reg != 2'd0) rf_wdata <= wb_matrix_line_data;
          else                                rf_wdata <= wb_alu_o;

          // MOPA wins over a single-line request; line 0 leaves immediately.
          if (wb_matrix_write_mopa) begin
            for (int i = 1; i < MLINES; i++) mopa_buf[i] <= wb_matrix_mul_o[i];
            mx_we    <= 1'b1;
            mx_waddr <= 2'd0;
            mx_wdata <= wb_matrix_mul_o[0];
            cnt      <= 2'd1;
            state    <= S_MOPA;
          end else if (wb_matrix_write) begin
            mx_we    <= 1'b1;
            mx_waddr <= wb_matrix_index;
            if (wb_mem2matrix)          mx_wdata <= wb_mem_data;
            else if (wb_mem_reg2matrix) mx_wdata <= wb_regs_data1;
            else                        mx_wdata <= wb_alu_o;
          end

          if (wb_inst != 32'd0) begin
            commit_valid <= 1'b1;
            commit_inst  <= wb_inst;
            retire_cnt   <= retire_cnt + CNT_W'(1);
          end
        end
        S_MOPA: begin
          mx_we    <= 1'b1;
          mx_waddr <= cnt;
          mx_wdata <= mopa_buf[cnt];
          cnt      <= cnt + 2'd1;
          if (cnt == 2'd3) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed steps then random traffic, checked against
// a transaction-level model holding pending MOPA lines in a queue.
module tb_wb_commit_unit;

  localparam int XLEN = 32;

  logic clk;
  logic rst;
  logic [XLEN-1:0] wb_mem_data, wb_alu_o, wb_matrix_line_data, wb_regs_data1;
  logic [4:0]  wb_rd;
  logic        wb_mem2reg, wb_regs_write, wb_mem2matrix, wb_matrix_write;
  logic        wb_matrix_write_mopa, wb_mem_reg2matrix;
  logic [1:0]  wb_matrix_index, wb_mem_matrix2reg;
  logic [3:0][XLEN-1:0] wb_matrix_mul_o;
  logic [31:0] wb_inst;
  logic        rf_we, mx_we, wb_stall, commit_valid, dbg_state;
  logic [4:0]  rf_waddr;
  logic [1:0]  mx_waddr;
  logic [XLEN-1:0] rf_wdata, mx_wdata;
  logic [31:0] commit_inst, retire_cnt;

  wb_commit_unit dut (
    .clk(clk), .rst(rst),
    .wb_mem_data(wb_mem_data), .wb_alu_o(wb_alu_o), .wb_rd(wb_rd),
    .wb_mem2reg(wb_mem2reg), .wb_regs_write(wb_regs_write),
    .wb_matrix_index(wb_matrix_index), .wb_mem2matrix(wb_mem2matrix),
    .wb_matrix_write(wb_matrix_write), .wb_matrix_write_mopa(wb_matrix_write_mopa),
    .wb_mem_matrix2reg(wb_mem_matrix2reg), .wb_matrix_line_data(wb_matrix_line_data),
    .wb_mem_reg2matrix(wb_mem_reg2matrix), .wb_regs_data1(wb_regs_data1),
    .wb_matrix_mul_o(wb_matrix_mul_o), .wb_inst(wb_inst),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mx_we(mx_we), .mx_waddr(mx_waddr), .mx_wdata(mx_wdata),
    .wb_stall(wb_stall), .commit_valid(commit_valid), .commit_inst(commit_inst),
    .retire_cnt(retire_cnt), .dbg_state(dbg_state)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: pending MOPA lines {addr, data} plus last output values
  logic [XLEN+1:0] exp_q[$];
  logic        m_rf_we, m_mx_we, m_cv, m_stall;
  logic [4:0]  m_rf_waddr;
  logic [1:0]  m_mx_waddr;
  logic [XLEN-1:0] m_rf_wdata, m_mx_wdata;
  logic [31:0] m_ci, m_rc;
  int stall_hi, mx_we_hi;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    exp_q.delete();
    m_rf_we = 0; m_mx_we = 0; m_cv = 0;
    m_rf_waddr = 0; m_mx_waddr = 0; m_rf_wdata = 0; m_mx_wdata = 0;
    m_ci = 0; m_rc = 0;
  endtask

  task automatic m_edge();
    logic [XLEN+1:0] e;
    m_rf_we = 0; m_mx_we = 0; m_cv = 0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_mx_we = 1; m_mx_waddr = e[XLEN+1:XLEN]; m_mx_wdata = e[XLEN-1:0];
    end else begin
      m_rf_we    = wb_regs_write && wb_rd != 0;
      m_rf_waddr = wb_rd;
      m_rf_wdata = wb_mem2reg ? wb_mem_data :
                   (wb_mem_matrix2reg != 0 ? wb_matrix_line_data : wb_alu_o);
      if (wb_matrix_write_mopa) begin
        m_mx_we = 1; m_mx_waddr = 0; m_mx_wdata = wb_matrix_mul_o[0];
        for (int i = 1; i < 4; i++) exp_q.push_back({2'(i), wb_matrix_mul_o[i]});
      end else if (wb_matrix_write) begin
        m_mx_we = 1; m_mx_waddr = wb_matrix_index;
        m_mx_wdata = wb_mem2matrix ? wb_mem_data :
                     (wb_mem_reg2matrix ? wb_regs_data1 : wb_alu_o);
      end
      if (wb_inst != 0) begin
        m_cv = 1; m_ci = wb_inst; m_rc = m_rc + 1;
      end
    end
  endtask

  task automatic chk_outputs();
    chk("rf_we", rf_we, m_rf_we);
    chk("rf_waddr", rf_waddr, m_rf_waddr);
    chk("rf_wdata", rf_wdata, m_rf_wdata);
    chk("mx_we", mx_we, m_mx_we);
    chk("mx_waddr", mx_waddr, m_mx_waddr);
    chk("mx_wdata", mx_wdata, m_mx_wdata);
    chk("commit_valid", commit_valid, m_cv);
    chk("commit_inst", commit_inst, m_ci);
    chk("retire_cnt", retire_cnt, m_rc);
    chk("dbg_state", dbg_state, exp_q.size() > 0);
  endtask

  // driver tasks: inputs change right after a falling edge
  task automatic run_cycle();
    #1;
    m_stall = (exp_q.size() > 1) || (exp_q.size() == 0 && wb_matrix_write_mopa);
    chk("wb_stall", wb_stall, m_stall);
    if (wb_stall === 1'b1) stall_hi++;
    m_edge();
    @(posedge clk); #1;
    if (mx_we === 1'b1) mx_we_hi++;
    chk_outputs();
    @(negedge clk);
  endtask

  task automatic run_held();
    do run_cycle(); while (m_stall);
  endtask

  task automatic clear_inputs();
    wb_mem_data = 0; wb_alu_o = 0; wb_rd = 0; wb_mem2reg = 0; wb_regs_write = 0;
    wb_matrix_index = 0; wb_mem2matrix = 0; wb_matrix_write = 0;
    wb_matrix_write_mopa = 0; wb_mem_matrix2reg = 0; wb_matrix_line_data = 0;
    wb_mem_reg2matrix = 0; wb_regs_data1 = 0; wb_matrix_mul_o = '0; wb_inst = 0;
  endtask

  task automatic set_random();
    wb_mem_data = $urandom; wb_alu_o = $urandom; wb_rd = 5'($urandom_range(0, 31));
    wb_mem2reg = 1'($urandom_range(0, 1)); wb_regs_write = 1'($urandom_range(0, 1));
    wb_matrix_index = 2'($urandom_range(0, 3)); wb_mem2matrix = 1'($urandom_range(0, 1));
    wb_matrix_write = 1'($urandom_range(0, 1));
    wb_matrix_write_mopa = ($urandom_range(0, 5) == 0);
    wb_mem_matrix2reg = 2'($urandom_range(0, 3)); wb_matrix_line_data = $urandom;
    wb_mem_reg2matrix = 1'($urandom_range(0, 1)); wb_regs_data1 = $urandom;
    for (int i = 0; i < 4; i++) wb_matrix_mul_o[i] = $urandom;
    wb_inst = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
  endtask

  initial begin
    bit hold;
    rst = 1'b0;
    clear_inputs();
    wb_matrix_write_mopa = 1'b1;
    m_reset();
    @(negedge clk); @(negedge clk);
    chk("reset_stall", wb_stall, 1'b0);
    chk_outputs();
    wb_matrix_write_mopa = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // ALU op to x5
    wb_rd = 5; wb_alu_o = 32'h1234; wb_regs_write = 1; wb_inst = 32'h00A00293;
    run_cycle();
    chk("alu_retire_cnt", retire_cnt, 32'd1);

    // load to x0: no write, still retires
    clear_inputs();
    wb_mem2reg = 1; wb_mem_data = 32'hDEADBEEF; wb_regs_write = 1; wb_inst = 32'h00002003;
    run_cycle();
    chk("x0_rf_we", rf_we, 1'b0);

    // single-line matrix write from memory
    clear_inputs();
    wb_matrix_write = 1; wb_matrix_index = 2; wb_mem2matrix = 1;
    wb_mem_data = 32'hCAFE0001; wb_inst = 32'h0000000B;
    stall_hi = 0;
    run_cycle();
    chk("mx_line_stall", stall_hi, 0);
    chk("mx_line_data", mx_wdata, 32'hCAFE0001);

    // MOPA held by upstream while stalled
    clear_inputs();
    wb_matrix_write_mopa = 1;
    wb_matrix_mul_o = {32'h44, 32'h33, 32'h22, 32'h11};
    wb_inst = 32'h0000005B;
    stall_hi = 0; mx_we_hi = 0;
    run_held();
    chk("mopa_stall_cycles", stall_hi, 3);
    chk("mopa_mx_writes", mx_we_hi, 4);
    chk("mopa_last_data", mx_wdata, 32'h44);
    chk("mopa_retire_cnt", retire_cnt, 32'd4);
    clear_inputs();
    run_cycle();

    // MOPA together with a scalar write and a dropped single-line request
    wb_matrix_write_mopa = 1; wb_matrix_write = 1; wb_matrix_index = 3;
    wb_regs_write = 1; wb_rd = 7; wb_alu_o = 32'h77;
    wb_matrix_mul_o = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    wb_inst = 32'h0000015B;
    run_held();
    clear_inputs();
    run_cycle();

    // reset after line 1 of a MOPA
    wb_matrix_write_mopa = 1;
    wb_matrix_mul_o = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    wb_inst = 32'h0000025B;
    run_cycle();
    run_cycle();
    #2 rst = 1'b0;
    m_reset();
    #1;
    chk("midreset_stall", wb_stall, 1'b0);
    chk_outputs();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    run_cycle();
    run_cycle();
    wb_rd = 9; wb_alu_o = 32'h9999; wb_regs_write = 1; wb_inst = 32'h00900493;
    run_cycle();
    chk("post_reset_retire", retire_cnt, 32'd1);

    // random traffic, inputs held whenever the model says stall
    hold = 0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) set_random();
      run_cycle();
      hold = m_stall;
    end
    clear_inputs();
    repeat (4) run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
